// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt encoder.
package irq_pkg;

   localparam int unsigned NDefault = 8;
   localparam int unsigned WDefault = 3;

   // Handshake states; the unused encoding 2'b11 recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StReq     = 2'b01,
      StService = 2'b10
   } state_e;

endpackage

// File: rtl/prienc.sv
// Combinational lowest-index priority encoder.
module prienc #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] a,
   output logic [W-1:0] y,
   output logic         valid
);

   // Scan from the top down so the lowest set index is the last to write y.
   always_comb begin
      y     = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (a[i]) begin
            y     = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_encoder.sv
// Interrupt request encoder: edge capture, pending/mask, priority encode and
// req/ack/eoi handshake towards the core's exception logic.
module irq_encoder
   import irq_pkg::*;
#(
   parameter int unsigned N = NDefault,
   parameter int unsigned W = WDefault
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] irq,
   input  logic [N-1:0] mask,
   input  logic         ack,
   input  logic         eoi,
   input  logic         clr_ovr,
   output logic         req,
   output logic [W-1:0] code,
   output logic [N-1:0] pending,
   output logic         overrun
);

   logic [N-1:0] irq_q;
   logic [N-1:0] pending_q, pending_d;
   logic         overrun_q, overrun_d;
   logic [N-1:0] rise;
   logic [N-1:0] ack_clr;
   logic [W-1:0] enc_idx;
   logic         enc_valid;
   state_e       state_q;
   logic         req_q;
   logic [W-1:0] code_q;

   prienc #(
      .N(N),
      .W(W)
   ) u_prienc (
      .a    (pending_q & mask),
      .y    (enc_idx),
      .valid(enc_valid)
   );

   // Next pending/overrun: a new edge beats both the ack-clear and clr_ovr.
   always_comb begin
      rise      = irq & ~irq_q;
      ack_clr   = '0;
      if (state_q == StReq && ack) begin
         ack_clr = N'(1) << code_q;
      end
      pending_d = rise | (pending_q & ~ack_clr);
      overrun_d = (|(rise & pending_q)) | (overrun_q & ~clr_ovr);
   end

   // Edge-detect, pending and overrun registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_q     <= '0;
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         irq_q     <= irq;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   // Handshake FSM with registered req and code outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (enc_valid) begin
                  code_q  <= enc_idx;
                  req_q   <= 1'b1;
                  state_q <= StReq;
               end
            end
            StReq: begin
               // ack beats withdrawal when the line is masked in the same cycle.
               if (ack) begin
                  req_q   <= 1'b0;
                  state_q <= StService;
               end else if (!mask[code_q]) begin
                  req_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            StService: begin
               if (eoi) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req     = req_q;
   assign code    = code_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Directed self-checking bench for irq_encoder.
module tb_irq_encoder;

   logic       clk;
   logic       reset;
   logic [7:0] irq;
   logic [7:0] mask;
   logic       ack;
   logic       eoi;
   logic       clr_ovr;
   logic       req;
   logic [2:0] code;
   logic [7:0] pending;
   logic       overrun;

   int checks;
   int failures;

   irq_encoder #(
      .N(8),
      .W(3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .irq    (irq),
      .mask   (mask),
      .ack    (ack),
      .eoi    (eoi),
      .clr_ovr(clr_ovr),
      .req    (req),
      .code   (code),
      .pending(pending),
      .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic r, input logic [2:0] c,
                          input logic [7:0] p, input logic o);
      chk({tag, ".req"}, 8'(req), 8'(r));
      chk({tag, ".code"}, 8'(code), 8'(c));
      chk({tag, ".pending"}, pending, p);
      chk({tag, ".overrun"}, 8'(overrun), 8'(o));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      irq      = 8'h00;
      mask     = 8'hFF;
      ack      = 1'b0;
      eoi      = 1'b0;
      clr_ovr  = 1'b0;
      step();
      step();
      reset = 1'b1;
      chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
      step();
      chk_out("idle", 1'b0, 3'd0, 8'h00, 1'b0);

      // Reset mid-REQ
      irq = 8'h20;
      step();
      chk_out("r5_pend", 1'b0, 3'd0, 8'h20, 1'b0);
      step();
      chk_out("r5_req", 1'b1, 3'd5, 8'h20, 1'b0);
      reset = 1'b0;
      irq   = 8'h00;
      step();
      chk_out("r5_rst", 1'b0, 3'd0, 8'h00, 1'b0);
      reset = 1'b1;
      step();
      irq = 8'h20;
      step();
      chk_out("r5_again1", 1'b0, 3'd0, 8'h20, 1'b0);
      step();
      chk_out("r5_again2", 1'b1, 3'd5, 8'h20, 1'b0);
      ack = 1'b1;
      irq = 8'h00;
      step();
      chk_out("r5_ack", 1'b0, 3'd5, 8'h00, 1'b0);
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      step();

      // Priority
      irq = 8'hA0;
      step();
      chk_out("pri_pend", 1'b0, 3'd5, 8'hA0, 1'b0);
      step();
      chk_out("pri_req5", 1'b1, 3'd5, 8'hA0, 1'b0);
      ack = 1'b1;
      step();
      chk_out("pri_ack5", 1'b0, 3'd5, 8'h80, 1'b0);
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      chk_out("pri_eoi", 1'b0, 3'd5, 8'h80, 1'b0);
      step();
      chk_out("pri_req7", 1'b1, 3'd7, 8'h80, 1'b0);
      ack = 1'b1;
      step();
      chk_out("pri_ack7", 1'b0, 3'd7, 8'h00, 1'b0);
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      irq = 8'h00;
      step();

      // Mask and withdrawal
      mask = 8'hFE;
      irq  = 8'h01;
      step();
      chk_out("msk_pend", 1'b0, 3'd7, 8'h01, 1'b0);
      step();
      chk_out("msk_hold", 1'b0, 3'd7, 8'h01, 1'b0);
      mask = 8'hFF;
      step();
      chk_out("msk_req", 1'b1, 3'd0, 8'h01, 1'b0);
      mask = 8'hFE;
      step();
      chk_out("msk_wdraw", 1'b0, 3'd0, 8'h01, 1'b0);

      // Protocol abuse: ack in IDLE, eoi in REQ
      ack = 1'b1;
      step();
      chk_out("ack_idle", 1'b0, 3'd0, 8'h01, 1'b0);
      ack  = 1'b0;
      mask = 8'hFF;
      step();
      chk_out("abuse_req", 1'b1, 3'd0, 8'h01, 1'b0);
      eoi = 1'b1;
      step();
      chk_out("eoi_req", 1'b1, 3'd0, 8'h01, 1'b0);
      eoi = 1'b0;
      ack = 1'b1;
      step();
      chk_out("abuse_ack", 1'b0, 3'd0, 8'h00, 1'b0);
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      irq = 8'h00;
      step();

      // Simultaneous set/clear and overrun
      irq = 8'h08;
      step();
      step();
      chk_out("sim_req3", 1'b1, 3'd3, 8'h08, 1'b0);
      irq = 8'h00;
      step();
      chk_out("sim_fall", 1'b1, 3'd3, 8'h08, 1'b0);
      irq = 8'h08;
      ack = 1'b1;
      step();
      chk_out("sim_setclr", 1'b0, 3'd3, 8'h08, 1'b1);
      ack     = 1'b0;
      irq     = 8'h00;
      clr_ovr = 1'b1;
      step();
      chk_out("ovr_clr", 1'b0, 3'd3, 8'h08, 1'b0);
      irq = 8'h08;
      step();
      chk_out("ovr_setwins", 1'b0, 3'd3, 8'h08, 1'b1);
      clr_ovr = 1'b0;
      eoi     = 1'b1;
      step();
      eoi = 1'b0;
      step();
      chk_out("sim_req3b", 1'b1, 3'd3, 8'h08, 1'b1);
      ack = 1'b1;
      step();
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi     = 1'b0;
      irq     = 8'h00;
      clr_ovr = 1'b1;
      step();
      clr_ovr = 1'b0;
      chk_out("sim_done", 1'b0, 3'd3, 8'h00, 1'b0);

      // Held-high line captures a single event
      irq = 8'h04;
      step();
      step();
      chk_out("hold_req", 1'b1, 3'd2, 8'h04, 1'b0);
      ack = 1'b1;
      step();
      ack = 1'b0;
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      step();
      step();
      step();
      chk_out("hold_once", 1'b0, 3'd2, 8'h00, 1'b0);
      irq = 8'h00;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_encoder.md
# irq_encoder

Interrupt request encoder for the pipelined MIPS core: captures rising edges on N raw interrupt lines into a pending register, applies an enable mask, and priority-encodes the lowest-numbered pending, enabled line into a binary cause code. It presents that code to the core's exception logic over a req/ack handshake. It then holds off further requests until the handler signals end-of-interrupt. It is the one-hot-to-binary counterpart of the core's one-hot decoders and sits between the external interrupt pins and the exception/cause path.

## Interface
- N, default 8: number of interrupt lines.
- W, default 3: code width; must equal ceil(log2 N), N ≥ 2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; 0 at a clock edge resets all state.
- irq  input  N  raw interrupt lines, level, synchronous to clk.
- mask  input  N  per-line enable, 1 = enabled.
- ack  input  1  core accepts the presented code.
- eoi  input  1  handler finished; one-cycle pulse.
- clr_ovr  input  1  clears the overrun flag.
- req  output  1  code valid, request to core.
- code  output  W  index of the line being requested or serviced.
- pending  output  N  pending register, masked lines included.
- overrun  output  1  sticky: an edge arrived on an already-pending line.

## Operation
- Edge detect: irq_q registers irq; reset value is all zeros. rise = irq & ~irq_q. A line that is high when reset is released counts as one event.
- Pending update per edge, per bit i: set if rise[i]; else clear if the ack-clear targets i; else hold. Set wins over a same-cycle clear.
- Overrun: set when rise[i] & pending[i] for any i, including a bit cleared in the same cycle. clr_ovr clears it; a same-cycle set wins.
- Candidate: cand = pending & mask. The priority encoder returns the lowest set index plus valid = |cand.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if valid, latch code ← encoded index and go to REQ; else stay.
  - REQ: req = 1 and code is held stable.
    - ack = 1: clear pending[code] and go to SERVICE. ack has priority over withdrawal.
    - ack = 0 and mask[code] = 0: withdraw to IDLE, leaving pending untouched.
    - Otherwise stay in REQ. A higher-priority line arriving during REQ does not replace code.
  - SERVICE: req = 0 and code holds the serviced index. eoi = 1 goes to IDLE.
- ack outside REQ and eoi outside SERVICE are ignored.
- Reset values: state IDLE, req 0, code 0, pending 0, overrun 0, irq_q 0.
- Reset asserted in any state, including mid-handshake, returns to the reset values at that edge; any in-flight request is lost.

## Timing
- irq rises before edge k: pending[i] is 1 after edge k, and req is 1 after edge k+1. Request latency is 2 cycles.
- Input changes affect outputs only through registers.
  - req and code are registered and change only at edges.
  - The only combinational path from inputs to outputs is none.
- ack sampled 1 at edge j in REQ: req = 0 and pending[code] = 0 after edge j.
- eoi at edge m in SERVICE: state IDLE after m. If another candidate is waiting, req is 1 after edge m+1.
- Back-to-back: one serviced interrupt costs at least 3 cycles (REQ, SERVICE, IDLE).
- The bus holds its value: code changes only on the IDLE→REQ transition and on reset.

## Structure
- Shared package (irq_pkg):
  - state enum: IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10; 2'b11 recovers to IDLE.
  - Default N/W constants.
- Sub-module prienc #(N, W): combinational lowest-index priority encoder; inputs a[N-1:0], outputs y[W-1:0] and valid. Reused by the exception logic.
- Top level contains irq_q, pending, overrun, the FSM and the code register.

## Test plan
- Reset mid-REQ: raise irq[5] with mask = 8'hFF and wait for req = 1, code = 5. Drive reset = 0 for one edge: req = 0, pending = 0, overrun = 0. A new irq[5] edge gives req two cycles later.
- Priority: irq = 8'b1010_0000 in one cycle, mask = 8'hFF → req, code = 5. Then:
  - ack → pending = 8'h80.
  - eoi → req with code = 7 two cycles after eoi.
- Mask and withdrawal:
  - mask = 8'hFE, irq[0] rises: pending = 8'h01, req stays 0.
  - Set mask[0] = 1 → req after 1 cycle.
  - Clear mask[0] before ack → req = 0 next cycle, pending still 8'h01.
- Simultaneous set/clear: ack for code 3 in the same cycle irq[3] re-rises after a fall → pending[3] = 1 and overrun = 1. In the same cycle as a new overrun, clr_ovr → overrun stays 1.
- Protocol abuse: ack in IDLE and eoi in REQ are ignored; state and pending are unchanged. Hold irq[2] high continuously: only one event is captured and no overrun occurs.
